// File: rtl/mem_addr_gen_pkg.sv
// Shared constants, FSM state type and the digit-sum bank mapping used by the
// coefficient-memory sequencer and the NTT address unit.
package mem_addr_gen_pkg;

    localparam int DEGREE    = 4096;
    localparam int BANK_W    = 4;
    localparam int NUM_BANKS = 2 ** BANK_W;
    localparam int MA_W      = 8;
    localparam int IDX_W     = 12;
    localparam int D_W       = 32;
    localparam int RD_LAT    = 1;
    localparam int DIGITS    = IDX_W / BANK_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DUMP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Bank = sum of the BANK_W-bit digits of the index, wrapped to BANK_W bits.
    function automatic logic [BANK_W-1:0] bank_of(input logic [IDX_W-1:0] idx);
        logic [BANK_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < DIGITS; j++) begin
            acc = acc + idx[j*BANK_W +: BANK_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/mem_addr_gen_if.sv
// Control, fill-stream, memory-port and dump-stream signals of the sequencer.
// Handshake: a fill beat transfers on a cycle where in_valid and in_ready are both high; out_valid qualifies out_data/out_idx with no back-pressure.
interface mem_addr_gen_if;
    import mem_addr_gen_pkg::*;

    logic              start;
    logic              mode;
    logic              in_valid;
    logic [D_W-1:0]    in_data;
    logic              in_ready;
    logic [BANK_W-1:0] BN_idx;
    logic [MA_W-1:0]   MA_idx;
    logic [D_W-1:0]    data_in;
    logic              w_enable;
    logic              r_enable;
    logic [D_W-1:0]    memory_ans;
    logic              out_valid;
    logic [D_W-1:0]    out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, mode, in_valid, in_data, memory_ans,
        output in_ready, BN_idx, MA_idx, data_in, w_enable, r_enable,
               out_valid, out_data, out_idx, busy, done
    );

    modport slave (
        output start, mode, in_valid, in_data, memory_ans,
        input  in_ready, BN_idx, MA_idx, data_in, w_enable, r_enable,
               out_valid, out_data, out_idx, busy, done
    );

endinterface

// File: rtl/mem_addr_gen_bank_map.sv
// Combinational coefficient index -> (bank, address within bank) mapping.
module mem_addr_gen_bank_map
    import mem_addr_gen_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    output logic [BANK_W-1:0] bn_o,
    output logic [MA_W-1:0]   ma_o
);

    assign bn_o = bank_of(idx_i);
    assign ma_o = idx_i[IDX_W-1:BANK_W];

endmodule

// File: rtl/mem_addr_gen.sv
// Sequencer that walks indices 0..DEGREE-1, filling the banked memory from a
// stream or dumping it back out tagged with each coefficient's index.
module mem_addr_gen
    import mem_addr_gen_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mem_addr_gen_if.master bus,
    output state_e         state_o
);

    localparam logic [IDX_W-1:0] K_LAST     = IDX_W'(DEGREE - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [3:0]        drain_q, drain_d;
    logic [BANK_W-1:0] bn_q, bn_d;
    logic [MA_W-1:0]   ma_q, ma_d;
    logic [D_W-1:0]    din_q, din_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;

    logic [RD_LAT-1:0]            vld_pipe_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_pipe_q;

    logic [BANK_W-1:0] map_bn;
    logic [MA_W-1:0]   map_ma;

    mem_addr_gen_bank_map u_bank_map (
        .idx_i (k_q),
        .bn_o  (map_bn),
        .ma_o  (map_ma)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        bn_d    = '0;
        ma_d    = '0;
        din_d   = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        ridx_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = bus.mode ? ST_DUMP : ST_FILL;
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    we_d  = 1'b1;
                    bn_d  = map_bn;
                    ma_d  = map_ma;
                    din_d = bus.in_data;
                    if (k_q == K_LAST) state_d = ST_FIN;
                    else               k_d     = k_q + IDX_W'(1);
                end
            end
            ST_DUMP: begin
                re_d   = 1'b1;
                bn_d   = map_bn;
                ma_d   = map_ma;
                ridx_d = k_q;
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                // Wait for the last read's data to leave the delay line.
                if (drain_q == DRAIN_LAST) state_d = ST_FIN;
                else                       drain_d = drain_q + 4'd1;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            drain_q    <= '0;
            bn_q       <= '0;
            ma_q       <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            ridx_q     <= '0;
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            drain_q       <= drain_d;
            bn_q          <= bn_d;
            ma_q          <= ma_d;
            din_q         <= din_d;
            we_q          <= we_d;
            re_q          <= re_d;
            ridx_q        <= ridx_d;
            vld_pipe_q[0] <= re_q;
            idx_pipe_q[0] <= ridx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.BN_idx    = bn_q;
    assign bus.MA_idx    = ma_q;
    assign bus.data_in   = din_q;
    assign bus.w_enable  = we_q;
    assign bus.r_enable  = re_q;
    assign bus.out_valid = vld_pipe_q[RD_LAT-1];
    assign bus.out_idx   = idx_pipe_q[RD_LAT-1];
    assign bus.out_data  = vld_pipe_q[RD_LAT-1] ? bus.memory_ans : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign state_o       = state_q;

endmodule
